// File: rtl/word_align_pkg.sv
// ---------------------------------------------------------------------------
// word_align_pkg
// Shared constants and types for the word-alignment controller.
//   WORD_W / OFS_W     : deserialised word width and rotation-index width
//   SYNC_WORD_DEFAULT  : training pattern (all 8 rotations are distinct)
//   align_state_t      : controller state encoding, also exposed for debug
// ---------------------------------------------------------------------------
package word_align_pkg;

  localparam int WORD_W = 8;
  localparam int OFS_W  = 3;

  localparam logic [WORD_W-1:0] SYNC_WORD_DEFAULT = 8'hAC;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SETTLE  = 4'd1,
    ST_SEARCH  = 4'd2,
    ST_CONFIRM = 4'd3,
    ST_LOCKED  = 4'd4
  } align_state_t;

endpackage

// File: rtl/word_barrel_shift.sv
// ---------------------------------------------------------------------------
// word_barrel_shift
// Selects an 8-bit window out of the last two deserialised words.
//   clk160      in  lane clock
//   rstb        in  asynchronous active-low reset
//   D_OUT_P     in  current deserialised word, bit 0 = earliest bit
//   bit_offset  in  rotation to apply (0 selects the previous word as-is)
//   data_out    out registered window
//   window      out combinational window, used for sync-word matching
// ---------------------------------------------------------------------------
module word_barrel_shift
  import word_align_pkg::*;
(
  input  logic              clk160,
  input  logic              rstb,
  input  logic [WORD_W-1:0] D_OUT_P,
  input  logic [OFS_W-1:0]  bit_offset,
  output logic [WORD_W-1:0] data_out,
  output logic [WORD_W-1:0] window
);

  logic [WORD_W-1:0]   d_prev;
  logic [2*WORD_W-1:0] cat;

  // Earlier word sits in the low half, so a larger offset reaches later bits.
  assign cat    = {D_OUT_P, d_prev};
  assign window = cat[bit_offset +: WORD_W];

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      d_prev   <= '0;
      data_out <= '0;
    end else begin
      d_prev   <= D_OUT_P;
      data_out <= window;
    end
  end

endmodule

// File: rtl/word_align_ctrl.sv
// ---------------------------------------------------------------------------
// word_align_ctrl
// Finds the word boundary in a bit-aligned lane by searching the 8 rotations
// for the sync word, locks after enough consecutive matches and then streams
// aligned bytes.
//   clk160          in  lane clock
//   rstb            in  asynchronous active-low reset
//   D_OUT_P         in  deserialised word, bit 0 = earliest bit
//   delay_ready     in  bit alignment settled
//   align_enable    in  level: run alignment / hold lock
//   reset_counters  in  synchronous clear of lock_count and align_error
//   data_out        out aligned word (registered, every cycle)
//   data_valid      out data_out valid (LOCKED only)
//   word_aligned    out high in LOCKED
//   bit_offset      out rotation currently applied
//   align_error     out sticky: a full 8-offset sweep finished without lock
//   lock_count      out saturating count of LOCKED entries
//   state_dbg       out current controller state
//
// Output handshake: data_valid is a pure valid qualifier with no ready
// back-pressure; the consumer must take data_out on every cycle where
// data_valid is high, and data_out carries no meaning otherwise.
// ---------------------------------------------------------------------------
module word_align_ctrl
  import word_align_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
  parameter int                LOCK_COUNT   = 16,
  parameter int                SEARCH_DWELL = 32,
  parameter int                SETTLE_CYC   = 4
) (
  input  logic              clk160,
  input  logic              rstb,
  input  logic [WORD_W-1:0] D_OUT_P,
  input  logic              delay_ready,
  input  logic              align_enable,
  input  logic              reset_counters,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              word_aligned,
  output logic [OFS_W-1:0]  bit_offset,
  output logic              align_error,
  output logic [7:0]        lock_count,
  output logic [3:0]        state_dbg
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);
  localparam logic [7:0] DWELL_LAST  = 8'(SEARCH_DWELL - 1);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);

  align_state_t state, state_nxt;
  logic [3:0]   settle_cnt, settle_nxt;
  logic [7:0]   dwell_cnt, dwell_nxt;
  logic [7:0]   match_cnt, match_nxt;
  logic [2:0]   sweep_cnt, sweep_nxt;
  logic [OFS_W-1:0] offset_nxt;
  logic         error_nxt;
  logic [7:0]   lock_cnt_nxt;
  logic         advance;
  logic         lock_entry;
  logic         run_ok;
  logic         match;
  logic [WORD_W-1:0] window;

  word_barrel_shift u_shift (
    .clk160     (clk160),
    .rstb       (rstb),
    .D_OUT_P    (D_OUT_P),
    .bit_offset (bit_offset),
    .data_out   (data_out),
    .window     (window)
  );

  assign run_ok = align_enable && delay_ready;
  assign match  = (window == SYNC_WORD);

  // Next-state and counter updates.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    dwell_nxt  = dwell_cnt;
    match_nxt  = match_cnt;
    advance    = 1'b0;
    lock_entry = 1'b0;

    // Losing enable or bit alignment outranks everything, even a lock.
    if (state != ST_IDLE && !run_ok) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run_ok) begin
            settle_nxt = SETTLE_INIT;
            state_nxt  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // SETTLE occupies exactly SETTLE_CYC cycles.
          if (settle_cnt <= 4'd1) begin
            settle_nxt = 4'd0;
            dwell_nxt  = 8'd0;
            state_nxt  = ST_SEARCH;
          end else begin
            settle_nxt = settle_cnt - 4'd1;
          end
        end
        ST_SEARCH: begin
          if (match) begin
            match_nxt = 8'd1;
            if (LOCK_COUNT == 1) begin
              state_nxt  = ST_LOCKED;
              lock_entry = 1'b1;
            end else begin
              state_nxt = ST_CONFIRM;
            end
          end else if (dwell_cnt == DWELL_LAST) begin
            advance = 1'b1;
          end else begin
            dwell_nxt = dwell_cnt + 8'd1;
          end
        end
        ST_CONFIRM: begin
          if (match) begin
            match_nxt = match_cnt + 8'd1;
            if (match_cnt == LOCK_LAST) begin
              state_nxt  = ST_LOCKED;
              lock_entry = 1'b1;
            end
          end else begin
            advance = 1'b1;
          end
        end
        ST_LOCKED: begin
          state_nxt = ST_LOCKED;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    if (advance) begin
      state_nxt  = ST_SETTLE;
      settle_nxt = SETTLE_INIT;
    end
  end

  // Offset, sweep and status updates.
  always_comb begin
    offset_nxt   = bit_offset;
    sweep_nxt    = sweep_cnt;
    error_nxt    = align_error;
    lock_cnt_nxt = lock_count;

    if (advance) begin
      offset_nxt = bit_offset + 3'd1;
      sweep_nxt  = sweep_cnt + 3'd1;
      // Eighth advance since the last lock: a full sweep found nothing.
      if (sweep_cnt == 3'd7) begin
        error_nxt = 1'b1;
      end
    end
    if (lock_entry) begin
      sweep_nxt = 3'd0;
      if (lock_count != 8'hFF) begin
        lock_cnt_nxt = lock_count + 8'd1;
      end
    end
    // Clearing wins over a coinciding increment or error.
    if (reset_counters) begin
      error_nxt    = 1'b0;
      lock_cnt_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      settle_cnt  <= 4'd0;
      dwell_cnt   <= 8'd0;
      match_cnt   <= 8'd0;
      sweep_cnt   <= 3'd0;
      bit_offset  <= '0;
      align_error <= 1'b0;
      lock_count  <= 8'd0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_nxt;
      dwell_cnt   <= dwell_nxt;
      match_cnt   <= match_nxt;
      sweep_cnt   <= sweep_nxt;
      bit_offset  <= offset_nxt;
      align_error <= error_nxt;
      lock_count  <= lock_cnt_nxt;
    end
  end

  assign word_aligned = (state == ST_LOCKED);
  assign data_valid   = (state == ST_LOCKED);
  assign state_dbg    = state;

endmodule

// File: tb/tb_word_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_word_align_ctrl
// Scoreboard bench for word_align_ctrl. The stimulus side predicts each lock
// event (edge, offset, lock_count) from the stream's bit phase and pushes it
// to exp_q; the monitor pops on every rising word_aligned and also checks
// every valid byte against the recorded input stream.
// ---------------------------------------------------------------------------
module tb_word_align_ctrl;
  import word_align_pkg::*;

  localparam int SETTLE = 4;
  localparam int DWELL  = 32;
  localparam int LOCKN  = 16;
  localparam int PER_OFS = SETTLE + DWELL;
  localparam int EXP_W  = 43;
  localparam int HN     = 8192;
  localparam logic [7:0] SYNC = 8'hAC;

  // ---------------- clock / reset ----------------
  logic clk160 = 1'b0;
  logic rstb;
  always #5 clk160 = ~clk160;

  int cyc = 0;
  always @(posedge clk160) cyc <= cyc + 1;

  logic [7:0] D_OUT_P;
  logic       delay_ready, align_enable, reset_counters;
  logic [7:0] data_out;
  logic       data_valid, word_aligned, align_error;
  logic [2:0] bit_offset;
  logic [7:0] lock_count;
  logic [3:0] state_dbg;

  word_align_ctrl #(
    .SYNC_WORD(SYNC), .LOCK_COUNT(LOCKN), .SEARCH_DWELL(DWELL), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk160(clk160), .rstb(rstb), .D_OUT_P(D_OUT_P), .delay_ready(delay_ready),
    .align_enable(align_enable), .reset_counters(reset_counters),
    .data_out(data_out), .data_valid(data_valid), .word_aligned(word_aligned),
    .bit_offset(bit_offset), .align_error(align_error), .lock_count(lock_count),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the controller's externally visible status.
  int model_ofs = 0;
  int model_lc  = 0;
  int model_adv = 0;
  bit model_err = 1'b0;

  // Stream generator: every word is SYNC rotated by the current bit phase.
  int pat_phase = 0;
  bit pat_zero  = 1'b0;
  int corrupt_cyc = -1;
  logic [7:0] hist [0:HN-1];

  function automatic logic [7:0] rotr8(input logic [7:0] v, input int s);
    logic [15:0] c;
    c = {v, v};
    return c[(s & 7) +: 8];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk160);
      #3;
    end
  endtask

  function automatic int lock_edge(input int d, input int nfail);
    return d + 1 + nfail * PER_OFS + SETTLE + LOCKN;
  endfunction

  task automatic expect_lock(input int edge_no, input int ofs, input bit cleared);
    if (cleared) model_lc = 0;
    else if (model_lc < 255) model_lc++;
    exp_q.push_back({32'(edge_no), 3'(ofs), 8'(model_lc)});
  endtask

  // Enable alignment on a clean stream of phase p and predict the lock.
  task automatic start_lock(input int p, input bit cleared);
    int d, lo, nf;
    pat_zero     = 1'b0;
    pat_phase    = p;
    align_enable = 1'b1;
    d  = cyc;
    lo = (8 - p) % 8;
    nf = (lo - model_ofs + 8) % 8;
    if (model_adv + nf >= 8) model_err = 1'b1;
    model_adv = 0;
    model_ofs = lo;
    expect_lock(lock_edge(d, nf), lo, cleared);
  endtask

  task automatic wait_locks(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL lock_timeout: %0d lock events still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic disable_align();
    align_enable = 1'b0;
    step(2);
  endtask

  task automatic model_reset();
    model_ofs = 0;
    model_lc  = 0;
    model_adv = 0;
    model_err = 1'b0;
  endtask

  // ---------------- driver: one word per cycle ----------------
  initial begin
    logic [7:0] w;
    D_OUT_P = 8'h00;
    forever begin
      @(posedge clk160);
      #2;
      w = pat_zero ? 8'h00 : rotr8(SYNC, pat_phase);
      if (cyc == corrupt_cyc) w = ~w;
      D_OUT_P = w;
      hist[cyc % HN] = w;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_wa;
    logic [EXP_W-1:0] e;
    logic [15:0] c;
    int mon_ofs;
    prev_wa = 1'b0;
    mon_ofs = 0;
    forever begin
      @(posedge clk160);
      #1;
      if (rstb === 1'b1) begin
        if (word_aligned && !prev_wa) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_lock: lock at offset %0d, none expected (cycle %0d)", bit_offset, cyc);
          end else begin
            e = exp_q.pop_front();
            mon_ofs = int'(e[10:8]);
            check("lock_edge", 64'(cyc), 64'(e[42:11]));
            check("lock_offset", 64'(bit_offset), 64'(e[10:8]));
            check("lock_count_at_lock", 64'(lock_count), 64'(e[7:0]));
          end
        end
        if (data_valid) begin
          c = {hist[(cyc - 1) % HN], hist[(cyc - 2) % HN]};
          check("valid_data", 64'(data_out), 64'(c[mon_ofs +: 8]));
        end
      end
      prev_wa = word_aligned;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d;
    rstb = 1'b0;
    align_enable = 1'b0;
    delay_ready = 1'b0;
    reset_counters = 1'b0;
    step(3);
    check("rst_data_out", 64'(data_out), 64'h0);
    check("rst_data_valid", 64'(data_valid), 64'h0);
    check("rst_word_aligned", 64'(word_aligned), 64'h0);
    check("rst_bit_offset", 64'(bit_offset), 64'h0);
    check("rst_align_error", 64'(align_error), 64'h0);
    check("rst_lock_count", 64'(lock_count), 64'h0);
    rstb = 1'b1;
    delay_ready = 1'b1;
    step(2);

    // Stream rotated so that offset 3 is the boundary; visits 0..2 first.
    start_lock(5, 1'b0);
    wait_locks(400);
    step(4);
    check("t1_data_is_sync", 64'(data_out), 64'(SYNC));
    check("t1_offset", 64'(bit_offset), 64'd3);
    disable_align();

    // Random phases, each starting from wherever the last lock left off.
    for (int r = 0; r < 4; r++) begin
      start_lock(int'($urandom_range(0, 7)), 1'b0);
      wait_locks(400);
      step(int'($urandom_range(4, 16)));
      check("rand_hold_lock", 64'(word_aligned), 64'd1);
      disable_align();
    end

    // Aligned stream from a fresh reset: lock 21 clocks after enable.
    rstb = 1'b0;
    step(1);
    rstb = 1'b1;
    model_reset();
    step(1);
    start_lock(0, 1'b0);
    wait_locks(400);
    check("t2_lock_count", 64'(lock_count), 64'd1);
    disable_align();

    // Lock at offset 5, then a one-cycle loss of delay_ready.
    start_lock(3, 1'b0);
    wait_locks(400);
    step(3);
    delay_ready = 1'b0;
    step(1);
    check("t5_valid_drop", 64'(data_valid), 64'd0);
    check("t5_aligned_drop", 64'(word_aligned), 64'd0);
    check("t5_offset_kept", 64'(bit_offset), 64'd5);
    delay_ready = 1'b1;
    start_lock(3, 1'b0);
    wait_locks(200);
    check("t5_relock_count", 64'(lock_count), 64'(model_lc));
    disable_align();

    // One corrupted word on the 10th match: advance, full sweep, relock.
    d = cyc;
    corrupt_cyc = d + 1 + SETTLE + 9;
    pat_zero = 1'b0;
    pat_phase = 3;
    align_enable = 1'b1;
    expect_lock(d + 1 + SETTLE + 10 + 7 * PER_OFS + SETTLE + LOCKN, 5, 1'b0);
    model_err = 1'b1;
    while (cyc < d + 1 + SETTLE + 10) step(1);
    check("t3_offset_advanced", 64'(bit_offset), 64'd6);
    check("t3_not_aligned", 64'(word_aligned), 64'd0);
    wait_locks(400);
    corrupt_cyc = -1;
    check("t3_align_error", 64'(align_error), 64'(model_err));
    disable_align();

    // Counter clear.
    reset_counters = 1'b1;
    step(1);
    reset_counters = 1'b0;
    model_lc = 0;
    model_err = 1'b0;
    check("rc_lock_count", 64'(lock_count), 64'd0);
    check("rc_align_error", 64'(align_error), 64'd0);

    // Constant zero input: never locks, error after one full sweep.
    pat_zero = 1'b1;
    align_enable = 1'b1;
    d = cyc;
    while (cyc < d + 1 + 3 * PER_OFS) step(1);
    check("t4_offset_wrap", 64'(bit_offset), 64'((model_ofs + 3) % 8));
    while (cyc < d + 8 * PER_OFS) step(1);
    check("t4_error_before", 64'(align_error), 64'd0);
    step(1);
    check("t4_error_set", 64'(align_error), 64'd1);
    check("t4_offset_back", 64'(bit_offset), 64'(model_ofs));
    check("t4_not_aligned", 64'(word_aligned), 64'd0);
    disable_align();

    // Asynchronous reset in the middle of CONFIRM.
    start_lock(3, 1'b0);
    d = cyc;
    exp_q.delete();
    while (cyc < d + 10) step(1);
    #1 rstb = 1'b0;
    #1;
    check("t6_rst_data_out", 64'(data_out), 64'h0);
    check("t6_rst_valid", 64'(data_valid), 64'h0);
    check("t6_rst_aligned", 64'(word_aligned), 64'h0);
    check("t6_rst_offset", 64'(bit_offset), 64'h0);
    check("t6_rst_error", 64'(align_error), 64'h0);
    check("t6_rst_lock_count", 64'(lock_count), 64'h0);
    align_enable = 1'b0;
    step(2);
    rstb = 1'b1;
    model_reset();
    step(1);

    // reset_counters on the lock edge: the clear wins.
    start_lock(0, 1'b1);
    d = cyc;
    while (cyc < d + SETTLE + LOCKN) step(1);
    reset_counters = 1'b1;
    step(1);
    reset_counters = 1'b0;
    wait_locks(100);
    step(2);
    check("t6_clear_wins", 64'(lock_count), 64'd0);
    check("t6_still_locked", 64'(word_aligned), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
